// File: rtl/m_ext_pkg.sv
// Shared RV32M divide types and constants used by the divide front-end and its core.
// The datapath width comes from the `XLEN macro and defaults to 32.
`ifndef XLEN
`define XLEN 32
`endif

package m_ext_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        DRAIN
    } div_state_e;

    localparam logic [`XLEN-1:0] DIV0_QUO = '1;
    localparam logic [`XLEN-1:0] INT_MIN  = {1'b1, {(`XLEN-1){1'b0}}};

    // Two's-complement negate; INT_MIN maps onto itself, which the core treats as unsigned.
    function automatic logic [`XLEN-1:0] negate_if(input logic neg, input logic [`XLEN-1:0] x);
        return neg ? ('0 - x) : x;
    endfunction

endpackage

// File: rtl/div_ctrl_divider.sv
// Unsigned restoring divider core: one quotient bit per cycle after start, then a one-cycle done pulse.
// Has no abort; once started it always runs to completion unless reset.
`ifndef XLEN
`define XLEN 32
`endif

module divider
    import m_ext_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);

    localparam int CW = $clog2(XLEN + 1);

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;

    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dsr_q};
        if (start_i && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = CW'(XLEN);
            quo_d  = dividend_i;
            rem_d  = '0;
            dsr_d  = divisor_i;
        end else if (busy_q) begin
            // diff's top bit set means the shifted remainder was smaller than the divisor
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
        end
    end

    assign done_o = done_q;
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/div_ctrl.sv
// RV32M divide front-end: sign handling, RISC-V special cases and valid/ready framing around `divider`.
// Define DIV_RESULT_CACHE_EN to add a one-entry result cache serving DIV/REM pairs on equal operands.
`ifndef XLEN
`define XLEN 32
`endif

module div_ctrl
    import m_ext_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] opr1_i,
    input  logic [XLEN-1:0] opr2_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    div_state_e      state_q, state_d;
    div_op_e         op_e;
    logic            sgn_in, is_rem_in, n1, n2;
    logic            div0, ovf, special, accept, cache_hit, core_start;
    logic [XLEN-1:0] mag1, mag2, special_res;
    logic            core_done;
    logic [XLEN-1:0] core_quo, core_rem, quo_fix, rem_fix;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    assign op_e      = div_op_e'(op_i);
    assign sgn_in    = (op_e == DIV) || (op_e == REM);
    assign is_rem_in = op_i[1];
    assign n1        = sgn_in & opr1_i[XLEN-1];
    assign n2        = sgn_in & opr2_i[XLEN-1];
    assign mag1      = negate_if(n1, opr1_i);
    assign mag2      = negate_if(n2, opr2_i);

    // Divide-by-zero and signed overflow bypass the core with RISC-V defined results
    assign div0        = (opr2_i == '0);
    assign ovf         = sgn_in && (opr1_i == INT_MIN) && (opr2_i == DIV0_QUO);
    assign special     = div0 || ovf;
    assign special_res = div0 ? (is_rem_in ? opr1_i : DIV0_QUO)
                              : (is_rem_in ? '0 : INT_MIN);
    assign accept      = (state_q == IDLE) && req_valid_i && !flush_i;

    assign quo_fix = negate_if(neg_quo_q, core_quo);
    assign rem_fix = negate_if(neg_rem_q, core_rem);

    divider #(.XLEN(XLEN)) u_divider (
        .clk        (clk),
        .rst        (rst),
        .start_i    (core_start),
        .dividend_i (mag1),
        .divisor_i  (mag2),
        .done_o     (core_done),
        .quo_o      (core_quo),
        .rem_o      (core_rem)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (special || cache_hit) ? RESP : BUSY;
            BUSY: begin
                if (flush_i)        state_d = core_done ? IDLE : DRAIN;
                else if (core_done) state_d = RESP;
            end
            RESP:    if (flush_i || rsp_ready_i) state_d = IDLE;
            DRAIN:   if (core_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        core_start  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                core_start  = accept && !special && !cache_hit;
            end
            RESP:    rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        if (accept) begin
            is_rem_d  = is_rem_in;
            neg_quo_d = n1 ^ n2;
            neg_rem_d = n1;
            if (special)        result_d = special_res;
            else if (cache_hit) result_d = cache_sel(is_rem_in);
        end
        if ((state_q == BUSY) && core_done && !flush_i)
            result_d = is_rem_q ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;

`ifdef DIV_RESULT_CACHE_EN
    logic            cache_valid_q, cache_valid_d;
    logic            cache_sgn_q, cache_sgn_d;
    logic [XLEN-1:0] cache_opr1_q, cache_opr1_d;
    logic [XLEN-1:0] cache_opr2_q, cache_opr2_d;
    logic [XLEN-1:0] cache_quo_q, cache_quo_d;
    logic [XLEN-1:0] cache_rem_q, cache_rem_d;

    assign cache_hit = cache_valid_q && !special && (opr1_i == cache_opr1_q)
                       && (opr2_i == cache_opr2_q) && (sgn_in == cache_sgn_q);

    function automatic logic [XLEN-1:0] cache_sel(input logic want_rem);
        return want_rem ? cache_rem_q : cache_quo_q;
    endfunction

    // The key is written at core start and only marked valid once that run completes undiscarded
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_sgn_d   = cache_sgn_q;
        cache_opr1_d  = cache_opr1_q;
        cache_opr2_d  = cache_opr2_q;
        cache_quo_d   = cache_quo_q;
        cache_rem_d   = cache_rem_q;
        if (core_start) begin
            cache_valid_d = 1'b0;
            cache_sgn_d   = sgn_in;
            cache_opr1_d  = opr1_i;
            cache_opr2_d  = opr2_i;
        end
        if ((state_q == BUSY) && core_done && !flush_i) begin
            cache_valid_d = 1'b1;
            cache_quo_d   = quo_fix;
            cache_rem_d   = rem_fix;
        end
        if (flush_i) cache_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_valid_q <= 1'b0;
            cache_sgn_q   <= 1'b0;
            cache_opr1_q  <= '0;
            cache_opr2_q  <= '0;
            cache_quo_q   <= '0;
            cache_rem_q   <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_sgn_q   <= cache_sgn_d;
            cache_opr1_q  <= cache_opr1_d;
            cache_opr2_q  <= cache_opr2_d;
            cache_quo_q   <= cache_quo_d;
            cache_rem_q   <= cache_rem_d;
        end
    end
`else
    assign cache_hit = 1'b0;

    function automatic logic [XLEN-1:0] cache_sel(input logic want_rem);
        return want_rem ? '0 : '0;
    endfunction
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed RISC-V corner cases, flush/reset scenarios and random ops
// checked against a signed/unsigned arithmetic reference model.
`timescale 1ns/1ps

module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] opr1_i = '0;
    logic [31:0] opr2_i = '0;
    logic        flush_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] result_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_i        (op_i),
        .opr1_i      (opr1_i),
        .opr2_i      (opr2_i),
        .flush_i     (flush_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference: RISC-V M semantics straight from integer arithmetic (SV / and % truncate toward zero)
    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic isSpecial(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

    // Issue one request, wait for its response, hold rsp_ready_i low for `hold` cycles, then consume it
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int hold, output int lat);
        logic [31:0] exp_v;
        exp_v = refModel(op, a, b);
        @(negedge clk);
        checkOutput("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        op_i        = op;
        opr1_i      = a;
        opr2_i      = b;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid_o) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("result", result_o, exp_v);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                checkOutput("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
                checkOutput("hold_result", result_o, exp_v);
            end
            rsp_ready_i = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready_i = 1'b0;
            checkOutput("rsp_released", {31'b0, rsp_valid_o}, 32'd0);
            checkOutput("ready_after_rsp", {31'b0, req_ready_o}, 32'd1);
        end
    endtask

    task automatic checkLatency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
        if (isSpecial(op, a, b)) checkOutput("lat_special", 32'(lat), 32'd1);
`ifndef DIV_RESULT_CACHE_EN
        else checkOutput("lat_core_gt1", {31'b0, lat > 1}, 32'd1);
`endif
    endtask

    logic [1:0]  dir_op   [12] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10,
                                   2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
    logic [31:0] dir_a    [12] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                                   32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b    [12] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                   32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int          dir_hold [12] = '{0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int          lat;
        int          waited;
        int          rsp_seen;
        logic [1:0]  op_r;
        logic [31:0] a_r;
        logic [31:0] b_r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        checkOutput("reset_result", result_o, 32'd0);
        checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(dir_op[i], dir_a[i], dir_b[i], dir_hold[i], lat);
            checkLatency(dir_op[i], dir_a[i], dir_b[i], lat);
        end

        // Flush three cycles into a DIVU: response dropped, front-end stalls until the core drains
        @(negedge clk);
        req_valid_i = 1'b1; op_i = 2'b01; opr1_i = 32'd100; opr2_i = 32'd7;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checkOutput("drain_req_ready", {31'b0, req_ready_o}, 32'd0);
        checkOutput("drain_busy", {31'b0, busy_o}, 32'd1);
        waited   = 0;
        rsp_seen = 0;
        while (!req_ready_o && waited < 200) begin
            if (rsp_valid_o) rsp_seen++;
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("drain_ends", {31'b0, req_ready_o}, 32'd1);
        checkOutput("drain_waited", {31'b0, waited > 0}, 32'd1);
        checkOutput("drain_no_rsp", 32'(rsp_seen), 32'd0);
        applyStimulus(2'b01, 32'd100, 32'd7, 0, lat);
        checkLatency(2'b01, 32'd100, 32'd7, lat);

        // Flush while a response is pending drops it
        @(negedge clk);
        req_valid_i = 1'b1; op_i = 2'b00; opr1_i = 32'd5; opr2_i = 32'd0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        checkOutput("resp_flush_pre", {31'b0, rsp_valid_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checkOutput("resp_flush_valid", {31'b0, rsp_valid_o}, 32'd0);
        checkOutput("resp_flush_ready", {31'b0, req_ready_o}, 32'd1);

        // Reset in the middle of a core run; the abandoned run must never surface
        @(negedge clk);
        req_valid_i = 1'b1; op_i = 2'b01; opr1_i = 32'd1000; opr2_i = 32'd3;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("midrst_ready", {31'b0, req_ready_o}, 32'd1);
        checkOutput("midrst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("midrst_result", result_o, 32'd0);
        rsp_seen = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid_o || busy_o) rsp_seen++;
        end
        checkOutput("midrst_quiet", 32'(rsp_seen), 32'd0);

`ifdef DIV_RESULT_CACHE_EN
        applyStimulus(2'b00, 32'd100, 32'd7, 0, lat);
        checkOutput("cache_fill_lat", {31'b0, lat > 1}, 32'd1);
        applyStimulus(2'b10, 32'd100, 32'd7, 0, lat);
        checkOutput("cache_hit_lat", 32'(lat), 32'd1);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        applyStimulus(2'b10, 32'd100, 32'd7, 0, lat);
        checkOutput("cache_flushed_lat", {31'b0, lat > 1}, 32'd1);
`endif

        for (int n = 0; n < 40; n++) begin
            op_r = 2'($urandom_range(0, 3));
            a_r  = $urandom;
            b_r  = $urandom;
            case ($urandom_range(0, 5))
                0:       b_r = 32'd0;
                1:       begin a_r = 32'h8000_0000; b_r = 32'hFFFF_FFFF; end
                2:       b_r = 32'($urandom_range(1, 15));
                3:       b_r = -32'($urandom_range(1, 15));
                default: ;
            endcase
            applyStimulus(op_r, a_r, b_r, $urandom_range(0, 2), lat);
            checkLatency(op_r, a_r, b_r, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
